// File: rtl/ifetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_ctrl_if
// Description : Signal bundle for the instruction-fetch sequencer: the
//               instruction-memory request/response channel, the redirect
//               port from execute/commit and the decode-side output register.
//               The master modport is the fetch controller's view; the slave
//               modport is the view of the surrounding memory/pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
interface ifetch_ctrl_if;

    // Instruction-memory request channel (one outstanding request)
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;

    // Instruction-memory response channel (single-cycle pulse, no back-pressure)
    logic        imem_resp_valid;
    logic [31:0] imem_resp_instr;
    logic        imem_resp_err;

    // Flush/restart request from execute or commit
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    // Decode-side output register
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic [63:0] out_pre_pc;
    logic        out_fault;

    // Number of instructions handed to decode
    logic [63:0] fetch_cnt;

    // Fetch controller side
    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_instr,
        input  imem_resp_err,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_pc,
        output out_instr,
        output out_pre_pc,
        output out_fault,
        output fetch_cnt
    );

    // Memory / pipeline side
    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_instr,
        output imem_resp_err,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_pc,
        input  out_instr,
        input  out_pre_pc,
        input  out_fault,
        input  fetch_cnt
    );

endinterface
`default_nettype wire

// File: rtl/ifetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_ctrl
// Description : Instruction-fetch sequencer. Holds the fetch PC, issues one
//               outstanding 32-bit fetch at a time, captures the response in
//               a one-entry output register for decode (static not-taken
//               prediction: pre_pc = pc + 4), squashes in-flight responses on
//               redirect and halts on a memory access fault.
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_ctrl #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic          clk,
    input  logic          rst,
    ifetch_ctrl_if.master bus
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_ST_REQ  = 2'd0;  // ready to issue a fetch
    localparam logic [1:0] c_ST_WAIT = 2'd1;  // one fetch in flight
    localparam logic [1:0] c_ST_HALT = 2'd2;  // parked after an access fault

    localparam logic [63:0] c_PC_STEP = 64'd4;
    localparam logic [63:0] c_CNT_ONE = 64'd1;

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [63:0] r_pc;
    logic        r_kill;       // the in-flight response belongs to a squashed path
    logic        r_out_valid;
    logic        r_out_fault;
    logic [63:0] r_out_pc;
    logic [31:0] r_out_instr;
    logic [63:0] r_fetch_cnt;

    // ------------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------------
    logic [1:0]  w_state_nxt;
    logic [63:0] w_pc_nxt;
    logic        w_kill_nxt;
    logic        w_out_valid_nxt;
    logic        w_out_fault_nxt;
    logic [63:0] w_out_pc_nxt;
    logic [31:0] w_out_instr_nxt;
    logic [63:0] w_fetch_cnt_nxt;

    // ------------------------------------------------------------------------
    // Handshake qualifiers
    // ------------------------------------------------------------------------
    logic w_out_free;   // output register is empty or is being emptied now
    logic w_req_valid;  // a fetch request is presented this cycle
    logic w_req_fire;   // the request is accepted by memory this cycle
    logic w_consume;    // decode takes the held entry this cycle

    // Issuing only when the output register will be free guarantees the
    // response always has somewhere to land, so responses never stall.
    // A redirect masks the request so a stale address is never accepted.
    assign w_out_free  = !r_out_valid || bus.out_ready;
    assign w_req_valid = (r_state == c_ST_REQ) && !bus.redirect_valid && w_out_free;
    assign w_req_fire  = w_req_valid && bus.imem_req_ready;
    assign w_consume   = r_out_valid && bus.out_ready;

    // Next-state and datapath update: redirect first, then per-state behaviour
    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_kill_nxt      = r_kill;
        w_out_valid_nxt = r_out_valid;
        w_out_fault_nxt = r_out_fault;
        w_out_pc_nxt    = r_out_pc;
        w_out_instr_nxt = r_out_instr;
        w_fetch_cnt_nxt = r_fetch_cnt;

        if (bus.redirect_valid) begin
            // The held entry is on the wrong path: discard it uncounted.
            w_pc_nxt        = bus.redirect_pc;
            w_out_valid_nxt = 1'b0;
            if ((r_state == c_ST_WAIT) && !bus.imem_resp_valid) begin
                // Response still outstanding: remember to drop it on arrival.
                w_kill_nxt  = 1'b1;
                w_state_nxt = c_ST_WAIT;
            end else begin
                // Nothing outstanding, or the response is dropped right now.
                w_kill_nxt  = 1'b0;
                w_state_nxt = c_ST_REQ;
            end
        end else begin
            // Decode handoff; a same-cycle response load below takes precedence.
            if (w_consume) begin
                w_out_valid_nxt = 1'b0;
                w_fetch_cnt_nxt = r_fetch_cnt + c_CNT_ONE;
            end

            case (r_state)
                c_ST_REQ: begin
                    if (w_req_fire) begin
                        w_state_nxt = c_ST_WAIT;
                    end
                end

                c_ST_WAIT: begin
                    if (bus.imem_resp_valid) begin
                        if (r_kill) begin
                            // Response of a squashed fetch: drop it.
                            w_kill_nxt  = 1'b0;
                            w_state_nxt = c_ST_REQ;
                        end else begin
                            w_out_valid_nxt = 1'b1;
                            w_out_pc_nxt    = r_pc;
                            w_out_instr_nxt = bus.imem_resp_instr;
                            w_out_fault_nxt = bus.imem_resp_err;
                            if (bus.imem_resp_err) begin
                                // Keep the faulting PC and stop fetching.
                                w_state_nxt = c_ST_HALT;
                            end else begin
                                w_pc_nxt    = r_pc + c_PC_STEP;
                                w_state_nxt = c_ST_REQ;
                            end
                        end
                    end
                end

                c_ST_HALT: begin
                    // Only a redirect or reset leaves HALT; the faulted
                    // entry drains through the handoff logic above.
                end

                default: begin
                    // Unreachable encoding: fall back to issuing fetches.
                    w_state_nxt = c_ST_REQ;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_REQ;
            r_pc        <= RESET_PC;
            r_kill      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_fault <= 1'b0;
            r_out_pc    <= 64'd0;
            r_out_instr <= 32'd0;
            r_fetch_cnt <= 64'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_kill      <= w_kill_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_fault <= w_out_fault_nxt;
            r_out_pc    <= w_out_pc_nxt;
            r_out_instr <= w_out_instr_nxt;
            r_fetch_cnt <= w_fetch_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // The request address is the PC register itself, so it cannot change
    // while a request waits for imem_req_ready (the PC only moves on a
    // response or a redirect, and a redirect withdraws the request).
    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = r_pc;
    assign bus.out_valid      = r_out_valid;
    assign bus.out_pc         = r_out_pc;
    assign bus.out_instr      = r_out_instr;
    assign bus.out_pre_pc     = r_out_pc + c_PC_STEP;
    assign bus.out_fault      = r_out_fault;
    assign bus.fetch_cnt      = r_fetch_cnt;

endmodule
`default_nettype wire
